// File: rtl/ddr3_reset_sequencer_if.sv
// Reset-sequencer bundle: PLL lock and IDELAYCTRL ready in, staged resets and status out.
interface ddr3_reset_sequencer_if;
    logic       i_pll_locked;
    logic       i_idelayctrl_rdy;
    logic       o_idelayctrl_rst;
    logic       o_phy_rst_n;
    logic       o_ctrl_rst_n;
    logic       o_ready;
    logic [2:0] o_state;
    logic [7:0] o_lock_loss_cnt;
    logic       o_timeout;

    modport master (
        output i_pll_locked, i_idelayctrl_rdy,
        input  o_idelayctrl_rst, o_phy_rst_n, o_ctrl_rst_n, o_ready,
               o_state, o_lock_loss_cnt, o_timeout
    );

    modport slave (
        input  i_pll_locked, i_idelayctrl_rdy,
        output o_idelayctrl_rst, o_phy_rst_n, o_ctrl_rst_n, o_ready,
               o_state, o_lock_loss_cnt, o_timeout
    );
endinterface

// File: rtl/ddr3_reset_sequencer.sv
// DDR3 PHY/controller reset sequencer: lock-stable -> IDELAYCTRL reset -> ready -> PHY -> controller.
// Optional IDELAYCTRL ready watchdog enabled by defining RST_SEQ_RDY_TIMEOUT_EN.
module ddr3_reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int IDELAY_RST_CYCLES  = 16,
    parameter int PHY_TO_CTRL_CYCLES = 64,
    parameter int RDY_TIMEOUT_CYCLES = 4096,
    parameter int CNT_W              = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    ddr3_reset_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_IDLY_RST  = 3'd1,
        S_WAIT_RDY  = 3'd2,
        S_PHY_REL   = 3'd3,
        S_RUN       = 3'd4
    } state_t;

    // Terminal counts; a zero-cycle parameter behaves as one cycle.
    localparam logic [CNT_W-1:0] LOCK_LAST = (LOCK_STABLE_CYCLES <= 1) ? '0 : CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLY_LAST = (IDELAY_RST_CYCLES  <= 1) ? '0 : CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] PHY_LAST  = (PHY_TO_CTRL_CYCLES <= 1) ? '0 : CNT_W'(PHY_TO_CTRL_CYCLES - 1);

    if (LOCK_STABLE_CYCLES >= 2**CNT_W || IDELAY_RST_CYCLES >= 2**CNT_W ||
        PHY_TO_CTRL_CYCLES >= 2**CNT_W || RDY_TIMEOUT_CYCLES >= 2**CNT_W) begin : g_bad_param
        $error("cycle parameter exceeds counter range");
    end

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    logic [1:0]       r_lock_sync;
    logic [1:0]       r_rdy_sync;
    logic             w_lock_s;
    logic             w_rdy_s;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_lock_loss;

    logic             r_idelayctrl_rst;
    logic             r_phy_rst_n;
    logic             r_ctrl_rst_n;
    logic             r_ready;
    logic [7:0]       r_lock_loss_cnt;

    // Reset asserts immediately, releases two edges later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_lock_sync <= '0;
            r_rdy_sync  <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], bus.i_pll_locked};
            r_rdy_sync  <= {r_rdy_sync[0],  bus.i_idelayctrl_rdy};
        end
    end
    assign w_lock_s = r_lock_sync[1];
    assign w_rdy_s  = r_rdy_sync[1];

`ifdef RST_SEQ_RDY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = (RDY_TIMEOUT_CYCLES <= 1) ? '0 : CNT_W'(RDY_TIMEOUT_CYCLES - 1);
    logic w_timeout_hit;
    logic r_timeout;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lock_loss = 1'b0;
`ifdef RST_SEQ_RDY_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        case (r_state)
            S_WAIT_LOCK: begin
                if (!w_lock_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_nxt = S_IDLY_RST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLY_RST: begin
                if (r_cnt == IDLY_LAST) begin
                    w_state_nxt = S_WAIT_RDY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_RDY: begin
                if (w_rdy_s) begin
                    w_state_nxt = S_PHY_REL;
                    w_cnt_nxt   = '0;
                end
`ifdef RST_SEQ_RDY_TIMEOUT_EN
                else if (r_cnt == TO_LAST) begin
                    w_state_nxt   = S_IDLY_RST;
                    w_cnt_nxt     = '0;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            S_PHY_REL: begin
                if (r_cnt == PHY_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase

        // Lock loss overrides every other transition, including a watchdog expiry.
        if (!w_lock_s && (r_state == S_IDLY_RST || r_state == S_WAIT_RDY ||
                          r_state == S_PHY_REL  || r_state == S_RUN)) begin
            w_state_nxt = S_WAIT_LOCK;
            w_cnt_nxt   = '0;
            w_lock_loss = 1'b1;
`ifdef RST_SEQ_RDY_TIMEOUT_EN
            w_timeout_hit = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state          <= S_WAIT_LOCK;
            r_cnt            <= '0;
            r_idelayctrl_rst <= 1'b0;
            r_phy_rst_n      <= 1'b0;
            r_ctrl_rst_n     <= 1'b0;
            r_ready          <= 1'b0;
            r_lock_loss_cnt  <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_idelayctrl_rst <= (w_state_nxt == S_IDLY_RST);
            r_phy_rst_n      <= (w_state_nxt == S_PHY_REL) || (w_state_nxt == S_RUN);
            r_ctrl_rst_n     <= (w_state_nxt == S_RUN);
            r_ready          <= (w_state_nxt == S_RUN);
            if (w_lock_loss && r_lock_loss_cnt != 8'hFF)
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

`ifdef RST_SEQ_RDY_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n)          r_timeout <= 1'b0;
        else if (w_timeout_hit) r_timeout <= 1'b1;
    end
    assign bus.o_timeout = r_timeout;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_idelayctrl_rst = r_idelayctrl_rst;
    assign bus.o_phy_rst_n      = r_phy_rst_n;
    assign bus.o_ctrl_rst_n     = r_ctrl_rst_n;
    assign bus.o_ready          = r_ready;
    assign bus.o_state          = r_state;
    assign bus.o_lock_loss_cnt  = r_lock_loss_cnt;

endmodule
